// File: rtl/global_defs.sv
// Global widths and matrix limits shared by the MPU datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package global_defs;

    localparam int FPBITS          = 31;  // element is FPBITS+1 bits wide
    localparam int MBITS           = 2;   // row index/size is MBITS+1 bits wide
    localparam int NBITS           = 2;   // column index/size is NBITS+1 bits wide
    localparam int MATRIX_REG_BITS = 2;   // register address is MATRIX_REG_BITS+1 bits wide
    localparam int M               = 4;   // largest legal row count
    localparam int N               = 4;   // largest legal column count

endpackage

// File: rtl/mpu_pkg.sv
// Shared MPU types: load/store FSM states, the store beat record, size check helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package mpu_pkg;

    import global_defs::*;

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_CHECK,
        LOAD_WRITE
    } load_state_t;

    typedef enum logic [1:0] {
        STORE_IDLE,
        STORE_CHECK,
        STORE_READ,
        STORE_DRAIN
    } store_state_t;

    // One outgoing beat: element plus its coordinates and the final-beat flag.
    typedef struct packed {
        logic [FPBITS:0] element;
        logic [MBITS:0]  i;
        logic [NBITS:0]  j;
        logic            last;
    } store_beat_t;

    // A matrix is storable when both dimensions are non-zero and within M x N.
    function automatic logic store_size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m != '0) && (n != '0) && (m <= M[MBITS:0]) && (n <= N[NBITS:0]);
    endfunction

endpackage

// File: rtl/mpu_store_fifo.sv
// Purpose: small synchronous FIFO of store_beat_t entries buffering register-file read returns.
// Latency: push visible at head the cycle after the push edge; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; the parent never relies on either.
// Ports: clk/rst_n (sync, active low), push/push_dat, pop, head, full, empty, count.
module mpu_store_fifo
    import mpu_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2,
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  store_beat_t   push_dat,
    input  logic          pop,
    output store_beat_t   head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    store_beat_t   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mpu_store.sv
// Purpose: streams one matrix from the register file to a memory sink, row-major, one element per beat.
// Latency: start sampled at edge 0 -> ack in cycle 2, first read in cycle 2, first valid beat in cycle 4.
// Backpressure: valid/ready on the sink side; reads are throttled so buffered + in-flight never exceed FIFO_DEPTH.
// Ports: store_en_in/mem_store_addr_in start a store, ack/error pulse the outcome; mem_store_* carry beats
//        and latched sizes; reg_store_* drive 1-cycle-latency reads and return data/sizes from the register file.
module mpu_store
    import global_defs::*, mpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     store_en_in,
    input  logic [MATRIX_REG_BITS:0] mem_store_addr_in,
    output logic                     mem_store_ack_out,
    output logic                     mem_store_error_out,
    output logic                     mem_store_valid_out,
    input  logic                     mem_store_ready_in,
    output logic [FPBITS:0]          mem_store_element_out,
    output logic [MBITS:0]           mem_i_store_loc_out,
    output logic [NBITS:0]           mem_j_store_loc_out,
    output logic [MBITS:0]           mem_m_store_size_out,
    output logic [NBITS:0]           mem_n_store_size_out,
    output logic                     mem_store_last_out,
    output logic                     reg_store_en_out,
    output logic [MATRIX_REG_BITS:0] reg_store_addr_out,
    output logic [MBITS:0]           reg_i_store_loc_out,
    output logic [NBITS:0]           reg_j_store_loc_out,
    input  logic [FPBITS:0]          reg_store_element_in,
    input  logic [MBITS:0]           reg_m_store_size_in,
    input  logic [NBITS:0]           reg_n_store_size_in
);

    localparam int             CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [MBITS:0] I_ONE = {{MBITS{1'b0}}, 1'b1};
    localparam logic [NBITS:0] J_ONE = {{NBITS{1'b0}}, 1'b1};

    store_state_t             state;
    store_state_t             state_nxt;
    logic [MATRIX_REG_BITS:0] addr_q;
    logic [MBITS:0]           m_q;
    logic [NBITS:0]           n_q;
    logic [MBITS:0]           i_q;
    logic [NBITS:0]           j_q;
    logic                     ack_q;
    logic                     err_q;

    // Tag of the read issued last cycle; its data arrives this cycle.
    logic                     infl_vld;
    logic [MBITS:0]           infl_i;
    logic [NBITS:0]           infl_j;
    logic                     infl_last;

    store_beat_t              push_dat;
    store_beat_t              head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;

    logic                     pop;
    logic                     size_ok;
    logic                     rd_last;
    logic                     can_issue;
    logic                     rd_en;

    assign size_ok = store_size_ok(reg_m_store_size_in, reg_n_store_size_in);
    assign pop     = !fifo_empty && mem_store_ready_in;
    assign rd_last = (i_q == m_q - I_ONE) && (j_q == n_q - J_ONE);

    // A read issued now lands in the FIFO two edges later; count the slot it will need
    // against what is buffered, what is already in flight and what leaves this cycle.
    assign can_issue = (!fifo_full || pop) &&
                       ((int'(fifo_count) + int'(infl_vld)) < (FIFO_DEPTH + int'(pop)));
    assign rd_en     = (state == STORE_READ) && can_issue;

    always_comb begin
        state_nxt = state;
        case (state)
            STORE_IDLE:  if (store_en_in) state_nxt = STORE_CHECK;
            STORE_CHECK: state_nxt = size_ok ? STORE_READ : STORE_IDLE;
            STORE_READ:  if (rd_en && rd_last) state_nxt = STORE_DRAIN;
            STORE_DRAIN: if (pop && head.last) state_nxt = STORE_IDLE;
            default:     state_nxt = STORE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= STORE_IDLE;
            addr_q    <= '0;
            m_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            infl_vld  <= 1'b0;
            infl_i    <= '0;
            infl_j    <= '0;
            infl_last <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (state == STORE_IDLE && store_en_in) begin
                addr_q <= mem_store_addr_in;
            end
            if (state == STORE_CHECK) begin
                if (size_ok) begin
                    m_q   <= reg_m_store_size_in;
                    n_q   <= reg_n_store_size_in;
                    i_q   <= '0;
                    j_q   <= '0;
                    ack_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (rd_en) begin
                // Wrap to (0,0) after the final read so pointers stay within m-1/n-1.
                if (j_q == n_q - J_ONE) begin
                    j_q <= '0;
                    i_q <= rd_last ? '0 : i_q + I_ONE;
                end else begin
                    j_q <= j_q + J_ONE;
                end
            end
            infl_vld  <= rd_en;
            infl_i    <= i_q;
            infl_j    <= j_q;
            infl_last <= rd_last;
        end
    end

    assign push_dat = '{element: reg_store_element_in, i: infl_i, j: infl_j, last: infl_last};

    mpu_store_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (infl_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Beat fields are forced to zero while nothing is valid so stale entries never leak out.
    assign mem_store_valid_out   = !fifo_empty;
    assign mem_store_element_out = fifo_empty ? '0 : head.element;
    assign mem_i_store_loc_out   = fifo_empty ? '0 : head.i;
    assign mem_j_store_loc_out   = fifo_empty ? '0 : head.j;
    assign mem_store_last_out    = !fifo_empty && head.last;
    assign mem_m_store_size_out  = m_q;
    assign mem_n_store_size_out  = n_q;
    assign mem_store_ack_out     = ack_q;
    assign mem_store_error_out   = err_q;
    assign reg_store_en_out      = rd_en;
    assign reg_store_addr_out    = addr_q;
    assign reg_i_store_loc_out   = i_q;
    assign reg_j_store_loc_out   = j_q;

endmodule

// File: tb/tb_mpu_store.sv
// Purpose: self-checking bench for mpu_store against a row-major beat-list reference model.
// Latency: n/a (testbench).
// Backpressure: sink ready driven always-on, alternating, or random per test.
module tb_mpu_store;

    import global_defs::*;

    localparam int DEPTH = 2;
    localparam int BW    = FPBITS + MBITS + NBITS + 4;
    localparam int LIMIT = 200;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     store_en_in = 1'b0;
    logic [MATRIX_REG_BITS:0] mem_store_addr_in = '0;
    logic                     mem_store_ack_out;
    logic                     mem_store_error_out;
    logic                     mem_store_valid_out;
    logic                     mem_store_ready_in = 1'b0;
    logic [FPBITS:0]          mem_store_element_out;
    logic [MBITS:0]           mem_i_store_loc_out;
    logic [NBITS:0]           mem_j_store_loc_out;
    logic [MBITS:0]           mem_m_store_size_out;
    logic [NBITS:0]           mem_n_store_size_out;
    logic                     mem_store_last_out;
    logic                     reg_store_en_out;
    logic [MATRIX_REG_BITS:0] reg_store_addr_out;
    logic [MBITS:0]           reg_i_store_loc_out;
    logic [NBITS:0]           reg_j_store_loc_out;
    logic [FPBITS:0]          reg_store_element_in = '0;
    logic [MBITS:0]           reg_m_store_size_in;
    logic [NBITS:0]           reg_n_store_size_in;

    // Register-file model: matrix contents and sizes per address.
    logic [FPBITS:0] mat [8][4][4];
    logic [MBITS:0]  msz [8];
    logic [NBITS:0]  nsz [8];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpu_store #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .store_en_in           (store_en_in),
        .mem_store_addr_in     (mem_store_addr_in),
        .mem_store_ack_out     (mem_store_ack_out),
        .mem_store_error_out   (mem_store_error_out),
        .mem_store_valid_out   (mem_store_valid_out),
        .mem_store_ready_in    (mem_store_ready_in),
        .mem_store_element_out (mem_store_element_out),
        .mem_i_store_loc_out   (mem_i_store_loc_out),
        .mem_j_store_loc_out   (mem_j_store_loc_out),
        .mem_m_store_size_out  (mem_m_store_size_out),
        .mem_n_store_size_out  (mem_n_store_size_out),
        .mem_store_last_out    (mem_store_last_out),
        .reg_store_en_out      (reg_store_en_out),
        .reg_store_addr_out    (reg_store_addr_out),
        .reg_i_store_loc_out   (reg_i_store_loc_out),
        .reg_j_store_loc_out   (reg_j_store_loc_out),
        .reg_store_element_in  (reg_store_element_in),
        .reg_m_store_size_in   (reg_m_store_size_in),
        .reg_n_store_size_in   (reg_n_store_size_in)
    );

    assign reg_m_store_size_in = msz[reg_store_addr_out];
    assign reg_n_store_size_in = nsz[reg_store_addr_out];

    always @(posedge clk) begin
        if (reg_store_en_out) begin
            reg_store_element_in <= mat[reg_store_addr_out][reg_i_store_loc_out[1:0]][reg_j_store_loc_out[1:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({mem_store_ack_out, mem_store_error_out, mem_store_valid_out, mem_store_element_out,
                    mem_i_store_loc_out, mem_j_store_loc_out, mem_m_store_size_out, mem_n_store_size_out,
                    mem_store_last_out, reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out,
                    reg_j_store_loc_out});
    endfunction

    function automatic logic [BW-1:0] cur_beat();
        return {mem_store_element_out, mem_i_store_loc_out, mem_j_store_loc_out, mem_store_last_out};
    endfunction

    // mode 0: always ready, mode 1: ready on odd cycles (1,0,1,0...), mode 2: random
    function automatic logic rdy_for(input int mode, input int rc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (rc % 2) == 1;
        return $urandom_range(0, 1) == 1;
    endfunction

    // Runs one store (or two back-to-back with store_en_in held high). Cycle numbers are
    // relative to edge 0, the edge that samples the first store_en_in.
    task automatic run_store(input logic [MATRIX_REG_BITS:0] a0, input logic [MATRIX_REG_BITS:0] a1,
                             input int nops, input int mode, input bit exp_err, input bit timing);
        logic [BW-1:0]            expq [$];
        logic [BW-1:0]            prev_beat;
        logic [BW-1:0]            ebeat;
        logic                     prev_vld;
        logic                     prev_rdy;
        logic                     done;
        logic [MATRIX_REG_BITS:0] a;
        int rc, reads, pops, acks, errs, lasts, first_vld, err_rc;
        int ack_rc [2];
        int last_rc [2];
        prev_beat = '0; prev_vld = 1'b0; prev_rdy = 1'b0; done = 1'b0;
        reads = 0; pops = 0; acks = 0; errs = 0; lasts = 0; first_vld = 0; err_rc = -1;
        ack_rc = '{-1, -1};
        last_rc = '{-1, -1};

        if (!exp_err) begin
            for (int op = 0; op < nops; op++) begin
                a = (op == 0) ? a0 : a1;
                for (int i = 0; i < int'(msz[a]); i++) begin
                    for (int j = 0; j < int'(nsz[a]); j++) begin
                        expq.push_back({mat[a][i][j], (MBITS+1)'(i), (NBITS+1)'(j),
                                        (i == int'(msz[a]) - 1) && (j == int'(nsz[a]) - 1)});
                    end
                end
            end
        end
        a = (nops == 2) ? a1 : a0;

        @(posedge clk); #1;
        mem_store_addr_in = a0;
        store_en_in = 1'b1;
        @(posedge clk); #1;
        if (nops == 1) store_en_in = 1'b0;
        else mem_store_addr_in = a1;
        rc = 1;
        mem_store_ready_in = rdy_for(mode, rc);

        while (!done && rc <= LIMIT) begin
            @(negedge clk);
            if (mem_store_ack_out) begin
                if (acks < 2) ack_rc[acks] = rc;
                acks++;
            end
            if (mem_store_error_out) begin
                errs++;
                err_rc = rc;
            end
            if (reg_store_en_out) reads++;
            if (mem_store_valid_out && first_vld == 0) first_vld = rc;
            if (prev_vld && !prev_rdy) begin
                chk("hold_stable", {mem_store_valid_out, cur_beat()}, {1'b1, prev_beat});
            end
            if (mem_store_valid_out && mem_store_ready_in) begin
                pops++;
                chk("beat_expected", expq.size() > 0, 1'b1);
                if (expq.size() > 0) begin
                    ebeat = expq.pop_front();
                    chk("beat", cur_beat(), ebeat);
                end
                if (mem_store_last_out) begin
                    if (lasts < 2) last_rc[lasts] = rc;
                    lasts++;
                    if (lasts == nops) begin
                        store_en_in = 1'b0;
                        done = 1'b1;
                    end
                end
            end
            chk("fifo_bound", (reads - pops) <= DEPTH, 1'b1);
            prev_vld  = mem_store_valid_out;
            prev_rdy  = mem_store_ready_in;
            prev_beat = cur_beat();
            if (exp_err && rc == 6) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
                rc++;
                mem_store_ready_in = rdy_for(mode, rc);
            end
        end

        chk("completed_in_budget", done, 1'b1);
        chk("beats_remaining", expq.size(), 0);
        if (exp_err) begin
            chk("error_count", errs, 1);
            chk("error_cycle", err_rc, 2);
            chk("no_ack", acks, 0);
            chk("no_reads", reads, 0);
            chk("no_valid", first_vld, 0);
        end else begin
            chk("ack_count", acks, nops);
            chk("ack_cycle", ack_rc[0], 2);
            chk("no_error", errs, 0);
            chk("m_size", mem_m_store_size_out, msz[a]);
            chk("n_size", mem_n_store_size_out, nsz[a]);
            if (nops == 2) chk("b2b_ack_cycle", ack_rc[1], last_rc[0] + 3);
        end
        if (timing) begin
            chk("first_valid_cycle", first_vld, 4);
            chk("last_beat_cycle", last_rc[0], 3 + int'(msz[a0]) * int'(nsz[a0]));
        end
    endtask

    initial begin
        int pops;

        for (int a = 0; a < 8; a++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    mat[a][i][j] = $urandom();
        msz[0] = 1; nsz[0] = 1;
        msz[1] = 2; nsz[1] = 3;
        mat[1][0][0] = 32'h3f80_0000; mat[1][0][1] = 32'h4000_0000; mat[1][0][2] = 32'h4040_0000;
        mat[1][1][0] = 32'h4080_0000; mat[1][1][1] = 32'h40a0_0000; mat[1][1][2] = 32'h40c0_0000;
        msz[2] = 0; nsz[2] = 2;
        msz[3] = 2; nsz[3] = (NBITS+1)'(N + 1);
        msz[4] = 1; nsz[4] = 1;
        mat[4][0][0] = 32'h4060_0000;
        msz[5] = 3; nsz[5] = 3;
        msz[6] = (MBITS+1)'(M); nsz[6] = (NBITS+1)'(N);
        msz[7] = (MBITS+1)'($urandom_range(1, M));
        nsz[7] = (NBITS+1)'($urandom_range(1, N));

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 64'd0);
        rst_n = 1'b1;

        run_store(1, 1, 1, 0, 1'b0, 1'b1);   // 2x3, ready always high, exact timing
        run_store(1, 1, 1, 1, 1'b0, 1'b0);   // 2x3, ready alternating
        run_store(2, 2, 1, 0, 1'b1, 1'b0);   // m == 0
        run_store(3, 3, 1, 0, 1'b1, 1'b0);   // n == N+1
        run_store(4, 4, 1, 0, 1'b0, 1'b1);   // 1x1

        // Reset in the middle of a 3x3 store, after the third beat.
        mem_store_addr_in  = 5;
        mem_store_ready_in = 1'b1;
        @(posedge clk); #1;
        store_en_in = 1'b1;
        @(posedge clk); #1;
        store_en_in = 1'b0;
        pops = 0;
        for (int k = 0; k < LIMIT && pops < 3; k++) begin
            @(negedge clk);
            if (mem_store_valid_out && mem_store_ready_in) pops++;
        end
        chk("reset_test_three_beats", pops, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midop_reset_outs", outs(), 64'd0);
        rst_n = 1'b1;

        run_store(5, 5, 1, 0, 1'b0, 1'b1);   // fresh 3x3 restarts at (0,0)
        run_store(1, 6, 2, 0, 1'b0, 1'b0);   // back-to-back, store_en held high
        run_store(6, 6, 1, 2, 1'b0, 1'b0);   // M x N, random ready
        run_store(7, 7, 1, 2, 1'b0, 1'b0);   // random size, random ready

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpu_store.md
Name: mpu_store

Overview:
- Moves one matrix from the register file to an external memory sink, one floating-point element per beat, in row-major order (column index fastest).
- Counterpart of the load path: register file --> external sink.
- Issues 1-cycle-latency reads to the register file and buffers returned elements in a small FIFO.
- Presents elements on a valid/ready interface, so the sink can apply backpressure.

Parameters:
- FIFO_DEPTH, 2, output buffer entries (min 2); each entry holds element, i, j and a last flag.
- Element and index widths come from the global_defs constants FPBITS, MBITS, NBITS, MATRIX_REG_BITS, M and N; they are not module parameters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- store_en_in  in  1  start request; sampled only in STORE_IDLE
- mem_store_addr_in  in  MATRIX_REG_BITS+1  matrix register to store
- mem_store_ack_out  out  1  one-cycle pulse: request accepted
- mem_store_error_out  out  1  one-cycle pulse: dimension error, request dropped
- mem_store_valid_out  out  1  element beat valid
- mem_store_ready_in  in  1  sink accepts beat
- mem_store_element_out  out  FPBITS+1  element data
- mem_i_store_loc_out  out  MBITS+1  element row
- mem_j_store_loc_out  out  NBITS+1  element column
- mem_m_store_size_out  out  MBITS+1  latched row count
- mem_n_store_size_out  out  NBITS+1  latched column count
- mem_store_last_out  out  1  qualifies the final beat (meaningful only with valid)
- reg_store_en_out  out  1  register-file read strobe
- reg_store_addr_out  out  MATRIX_REG_BITS+1  matrix address (held for the whole operation)
- reg_i_store_loc_out  out  MBITS+1  read row
- reg_j_store_loc_out  out  NBITS+1  read column
- reg_store_element_in  in  FPBITS+1  read data, valid 1 cycle after the strobe
- reg_m_store_size_in  in  MBITS+1  size of the matrix at reg_store_addr_out, combinational
- reg_n_store_size_in  in  NBITS+1  as above, columns

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset state: all outputs 0, state STORE_IDLE, FIFO empty, in-flight read discarded.
  - Applies equally to reset asserted mid-operation; no further beats appear.
- States: STORE_IDLE, STORE_CHECK, STORE_READ, STORE_DRAIN.
- STORE_IDLE:
  - store_en_in=1 at an edge -> latch mem_store_addr_in, go to STORE_CHECK.
  - store_en_in is ignored in every other state.
- STORE_CHECK (one cycle):
  - reg_store_addr_out is driven with the latched address; the sizes are sampled.
  - Error if m==0, n==0, m>M or n>N -> mem_store_error_out pulses in the next cycle, return to STORE_IDLE.
  - Otherwise latch m and n onto mem_m/n_store_size_out, pulse mem_store_ack_out in the next cycle, go to STORE_READ with read pointers i=j=0.
- STORE_READ:
  - Issue a read (reg_store_en_out=1, current i,j) when occupancy + inflight - pop < FIFO_DEPTH.
    - pop = valid && ready in this cycle.
  - Pointer advance per issued read: j+1; if j==n-1 then j=0 and i+1.
  - Read of (m-1,n-1) carries last=1; go to STORE_DRAIN after issuing it.
- Read return: reg_store_element_in is captured into the FIFO on the edge ending the cycle after the strobe, tagged with its i, j and last.
- STORE_DRAIN: no reads; go to STORE_IDLE on the edge where the last beat handshakes.
- Output beat:
  - mem_store_valid_out = FIFO not empty.
  - Element, i, j and last come from the FIFO head.
  - Once valid is high, data, i, j and last stay stable and valid stays high until ready=1.
- Latency: store_en_in sampled at edge 0 -> CHECK in cycle 1 -> first read in cycle 2 -> first valid in cycle 4.
- Throughput: 1 beat/cycle while ready=1; the m*n beats complete in m*n cycles after the first.
- Simultaneous events: FIFO push and pop in the same cycle leave occupancy unchanged; neither over- nor underflow is possible.
- Back-to-back stores: a new store_en_in is accepted at the first STORE_IDLE edge; the earliest is the edge after the last handshake.
- Boundaries:
  - 1x1 matrix: single beat, last=1.
  - m=M, n=N is legal.
  - Pointers never exceed m-1 and n-1.

Decomposition:
- mpu_pkg gains store_state_t (STORE_IDLE, STORE_CHECK, STORE_READ, STORE_DRAIN), alongside the load state type.
- mpu_pkg also gains a packed store_beat_t struct {element, i, j, last}.
- Sub-module mpu_store_fifo: synchronous FIFO, FIFO_DEPTH entries of store_beat_t.
  - Ports: push, pop, full, empty, count.
  - Same clock and reset as the parent.

Test Plan:
- 2x3 matrix at address 1, elements 1.0..6.0, ready=1 -> ack in cycle 2; beats (0,0)..(1,2) in cycles 4..9 with values 1.0..6.0; last only on (1,2); m=2, n=3 on the size outputs.
- Same 2x3 matrix, ready toggling 1,0,1,0 -> every beat held stable while ready=0; all 6 beats delivered in order with no duplicates or drops; reg_store_en_out never runs the FIFO past FIFO_DEPTH.
- Size m=0, then n=N+1 -> mem_store_error_out pulses in cycle 2; no ack, no reads, no valid; back in STORE_IDLE in cycle 2.
- 1x1 matrix, value 3.5 -> a single beat (0,0)=3.5 with last=1; return to STORE_IDLE on the handshake edge.
- rst_n=0 after the 3rd beat of a 3x3 store -> all outputs 0 the next cycle; a fresh store of the same matrix restarts at (0,0).
- store_en_in held high throughout two back-to-back stores -> second ack follows the first operation's last handshake; no overlap between the two.
